fp_compare_sequencer: RTL
=========================

Name: fp_compare_sequencer

Overview:
Multi-cycle controller that sequences an IEEE 754 single-precision comparison field by field: sign, then exponent, then mantissa. It terminates early as soon as one field decides the result. It sits between an upstream operand source and a downstream consumer, with valid/ready handshakes on both sides. It uses the team's 3-bit one-hot comparison encoding and adds NaN and signed-zero handling plus a completed-comparison counter.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, mantissa field width (total operand width W = 1+EXP_W+MAN_W)
CNT_W, 16, width of completed-comparison counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer can accept operands
a  input  W  operand A (IEEE 754)
b  input  W  operand B (IEEE 754)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  3  100 = A==B, 010 = A>B, 001 = A<B, 000 = unordered
unordered  output  1  at least one operand is NaN
decided_at  output  2  stage that decided: 0 sign/special, 1 exponent, 2 mantissa
busy  output  1  state != IDLE
cmp_count  output  CNT_W  completed comparisons, saturating

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=000, unordered=0, decided_at=0, busy=0, cmp_count=0, operand registers cleared.
- FSM states: IDLE, SIGN, EXP, MANT, DONE. One transition per clock.
- IDLE: in_ready=1. If in_valid=1, register a/b and go to SIGN. Otherwise stay in IDLE.
- in_ready is 1 only in IDLE. a/b changes while busy are ignored.
- SIGN, evaluated on the registered operands:
  - NaN means exp all-ones and mant!=0. If either operand is NaN: result=000, unordered=1, decided_at=0, go to DONE.
  - Zero means exp=0 and mant=0. If both are zero (any signs): result=100, decided_at=0, go to DONE. So +0 == -0.
  - Signs differ: the positive operand is greater (sa=0,sb=1 gives 010; sa=1,sb=0 gives 001), decided_at=0, go to DONE.
  - Signs equal: go to EXP.
- EXP: unsigned compare of exponents.
  - Unequal: the larger exponent has the larger magnitude. For positive operands the larger magnitude is greater; for negative operands the 010/001 result is swapped. decided_at=1, go to DONE.
  - Equal: go to MANT.
- MANT: unsigned mantissa compare with the same sign inversion. Equal gives 100. decided_at=2, go to DONE.
- Infinities need no special case: exp all-ones with mant=0 orders correctly through EXP/MANT.
- DONE: out_valid=1. result, unordered and decided_at are held stable until out_ready=1.
  - On out_ready=1: go to IDLE, out_valid falls next cycle, cmp_count increments.
  - cmp_count saturates at all-ones and does not wrap.
- result/unordered/decided_at are registered. They keep the last value after the handshake until the next decision.
- Latency, from the accept edge to the first cycle with out_valid=1: 2 cycles for a sign/special decision, 3 for exponent, 4 for mantissa.
- Throughput: at most one comparison per (latency+1) cycles. There is no overlap, because IDLE is revisited between operations.
- out_ready=1 while out_valid=0 has no effect.
- Reset asserted mid-operation (any state) aborts immediately and clears all outputs to their reset values. The in-flight comparison is lost and not counted.

Test Plan:
- Reset: hold rst_n=0 mid-MANT, release -> in_ready=1, out_valid=0, result=000, cmp_count=0.
- Sign decision and early termination: a=0x3F800000 (1.0), b=0xC0000000 (-2.0) -> result=010, decided_at=0, out_valid 2 cycles after accept. Swap operands -> result=001.
- Exponent decision with negative inversion:
  - a=0xC0000000 (-2.0), b=0xBF800000 (-1.0) -> result=001, decided_at=1, latency 3.
  - a=0x40000000, b=0x3F800000 -> 010.
- Mantissa decision and equality:
  - a=0xBFC00000 (-1.5), b=0xBF800000 (-1.0) -> result=001, decided_at=2, latency 4.
  - a=b=0x3FC00000 -> result=100, decided_at=2.
- Specials:
  - a=0x00000000, b=0x80000000 -> 100, decided_at=0.
  - a=0x7FC00000 (NaN), b=0x3F800000 -> result=000, unordered=1.
  - a=0x7F800000 (+inf), b=0x7F7FFFFF -> 010.
- Backpressure and counter: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE next cycle, cmp_count increments by 1. Force 2^CNT_W-1 completions (CNT_W=4 build) -> cmp_count stays 15.

Source files
------------

// File: rtl/fp_compare_sequencer_if.sv
// Operand/result handshake bundle for the field-by-field IEEE 754 comparator.
// slave = sequencer side, master = operand source / result consumer side.
interface fp_compare_sequencer_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [2:0]   result;
   logic         unordered;
   logic [1:0]   decided_at;

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, unordered, decided_at
   );

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, unordered, decided_at
   );
endinterface

// File: rtl/fp_compare_sequencer.sv
// Sequences a single-precision compare sign -> exponent -> mantissa, stopping at the
// first deciding field. Result encoding: 100 eq, 010 a>b, 001 a<b, 000 unordered.
module fp_compare_sequencer #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fp_compare_sequencer_if.slave io,
   output logic                  busy,
   output logic [CNT_W-1:0]      cmp_count
);
   localparam int W = 1 + EXP_W + MAN_W;

   typedef enum logic [2:0] {S_IDLE, S_SIGN, S_EXP, S_MANT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic [2:0]       result_q, result_d;
   logic             unord_q, unord_d;
   logic [1:0]       dec_q, dec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] ma, mb;
   logic             nan_a, nan_b, zero_a, zero_b;

   assign sa = a_q[W-1];
   assign sb = b_q[W-1];
   assign ea = a_q[W-2:MAN_W];
   assign eb = b_q[W-2:MAN_W];
   assign ma = a_q[MAN_W-1:0];
   assign mb = b_q[MAN_W-1:0];

   assign nan_a  = (&ea) && (|ma);
   assign nan_b  = (&eb) && (|mb);
   assign zero_a = ~(|ea) && ~(|ma);
   assign zero_b = ~(|eb) && ~(|mb);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      unord_d  = unord_q;
      dec_d    = dec_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (io.in_valid) begin
               a_d     = io.a;
               b_d     = io.b;
               state_d = S_SIGN;
            end
         end
         S_SIGN: begin
            state_d = S_DONE;
            dec_d   = 2'd0;
            unord_d = 1'b0;
            if (nan_a || nan_b) begin
               result_d = 3'b000;
               unord_d  = 1'b1;
            end else if (zero_a && zero_b) begin
               result_d = 3'b100;
            end else if (sa != sb) begin
               result_d = sa ? 3'b001 : 3'b010;
            end else begin
               state_d = S_EXP;
            end
         end
         S_EXP: begin
            // Same sign: larger magnitude wins for positives, loses for negatives.
            if (ea != eb) begin
               result_d = ((ea > eb) ^ sa) ? 3'b010 : 3'b001;
               unord_d  = 1'b0;
               dec_d    = 2'd1;
               state_d  = S_DONE;
            end else begin
               state_d = S_MANT;
            end
         end
         S_MANT: begin
            if (ma == mb) result_d = 3'b100;
            else          result_d = ((ma > mb) ^ sa) ? 3'b010 : 3'b001;
            unord_d = 1'b0;
            dec_d   = 2'd2;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (io.out_ready) begin
               state_d = S_IDLE;
               if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= 3'b000;
         unord_q  <= 1'b0;
         dec_q    <= 2'd0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         unord_q  <= unord_d;
         dec_q    <= dec_d;
         cnt_q    <= cnt_d;
      end
   end

   assign io.in_ready   = (state_q == S_IDLE);
   assign io.out_valid  = (state_q == S_DONE);
   assign io.result     = result_q;
   assign io.unordered  = unord_q;
   assign io.decided_at = dec_q;
   assign busy          = (state_q != S_IDLE);
   assign cmp_count     = cnt_q;
endmodule
